// File: rtl/bus_pkg.sv
// Shared widths, FSM encoding and the default response timeout for the
// two-requester bus arbiter.
package bus_pkg;

  localparam int ADDR_W          = 16;
  localparam int DATA_W          = 16;
  localparam int TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: one-hot grant, the requester not granted last
// wins a tie. Purely combinational.
module rr_pick2 (
  input  logic       i_valid0,
  input  logic       i_valid1,
  input  logic       i_last,
  output logic [1:0] o_grant
);

  // Tie goes to req0 only when req1 was the last one served
  always_comb begin
    o_grant = 2'b00;
    if (i_valid0 && (!i_valid1 || i_last)) begin
      o_grant = 2'b01;
    end else if (i_valid1) begin
      o_grant = 2'b10;
    end else begin
      o_grant = 2'b00;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter granting two requesters access to a core-chain bus,
// one outstanding transaction at a time, with a response timeout.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] req0_addr_i,
  input  logic [DATA_W-1:0] req0_data_i,
  input  logic              req0_rw_i,
  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  output logic [DATA_W-1:0] req0_rdata_o,
  output logic              req0_rvalid_o,
  output logic              req0_err_o,
  input  logic [ADDR_W-1:0] req1_addr_i,
  input  logic [DATA_W-1:0] req1_data_i,
  input  logic              req1_rw_i,
  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  output logic [DATA_W-1:0] req1_rdata_o,
  output logic              req1_rvalid_o,
  output logic              req1_err_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_data_o,
  output logic              bus_rw_o,
  output logic              bus_valid_o,
  input  logic [DATA_W-1:0] bus_data_i,
  input  logic              bus_rw_i,
  input  logic              bus_valid_i
);

  localparam logic [15:0] TMO_LIM = 16'(TIMEOUT_CYCLES - 32'd1);

  state_e            r_state;
  logic [15:0]       r_timer;
  logic              r_last;
  logic              r_owner;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [DATA_W-1:0] r_bus_data;
  logic              r_bus_rw;
  logic              r_bus_valid;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;
  logic [1:0]        r_rvalid;
  logic [1:0]        r_err;

  logic [1:0]        w_grant;
  logic [1:0]        w_ready;
  logic [15:0]       w_timer_nxt;
  logic              w_unused;

  // Responses are accepted the same way for reads and writes, so the returned rw is not needed
  assign w_unused    = bus_rw_i;
  assign w_timer_nxt = r_timer + 16'd1;

  rr_pick2 u_pick (
    .i_valid0 (req0_valid_i),
    .i_valid1 (req1_valid_i),
    .i_last   (r_last),
    .o_grant  (w_grant)
  );

  // Ready is offered only in IDLE and is held low while reset is asserted
  always_comb begin
    w_ready = 2'b00;
    if ((r_state == ST_IDLE) && rst_n) begin
      w_ready = w_grant;
    end else begin
      w_ready = 2'b00;
    end
  end

  // Arbitration FSM with registered bus and response outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_timer     <= 16'd0;
      r_last      <= 1'b1;
      r_owner     <= 1'b0;
      r_bus_addr  <= {ADDR_W{1'b0}};
      r_bus_data  <= {DATA_W{1'b0}};
      r_bus_rw    <= 1'b0;
      r_bus_valid <= 1'b0;
      r_rdata0    <= {DATA_W{1'b0}};
      r_rdata1    <= {DATA_W{1'b0}};
      r_rvalid    <= 2'b00;
      r_err       <= 2'b00;
    end else begin
      r_rvalid    <= 2'b00;
      r_err       <= 2'b00;
      r_bus_addr  <= {ADDR_W{1'b0}};
      r_bus_data  <= {DATA_W{1'b0}};
      r_bus_rw    <= 1'b0;
      r_bus_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_ready != 2'b00) begin
            r_owner     <= w_ready[1];
            r_bus_addr  <= w_ready[1] ? req1_addr_i : req0_addr_i;
            r_bus_data  <= w_ready[1] ? req1_data_i : req0_data_i;
            r_bus_rw    <= w_ready[1] ? req1_rw_i : req0_rw_i;
            r_bus_valid <= 1'b1;
            r_state     <= ST_ISSUE;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          r_timer <= 16'd0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          r_timer <= w_timer_nxt;
          // A response in the timeout cycle still wins over the error
          if (bus_valid_i || (w_timer_nxt == TMO_LIM)) begin
            if (r_owner) begin
              r_rdata1    <= bus_valid_i ? bus_data_i : {DATA_W{1'b0}};
              r_rvalid[1] <= 1'b1;
              r_err[1]    <= !bus_valid_i;
            end else begin
              r_rdata0    <= bus_valid_i ? bus_data_i : {DATA_W{1'b0}};
              r_rvalid[0] <= 1'b1;
              r_err[0]    <= !bus_valid_i;
            end
            r_last  <= r_owner;
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_WAIT;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign req0_ready_o  = w_ready[0];
  assign req1_ready_o  = w_ready[1];
  assign req0_rdata_o  = r_rdata0;
  assign req1_rdata_o  = r_rdata1;
  assign req0_rvalid_o = r_rvalid[0];
  assign req1_rvalid_o = r_rvalid[1];
  assign req0_err_o    = r_err[0];
  assign req1_err_o    = r_err[1];
  assign bus_addr_o    = r_bus_addr;
  assign bus_data_o    = r_bus_data;
  assign bus_rw_o      = r_bus_rw;
  assign bus_valid_o   = r_bus_valid;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed, table-driven bench for bus_arbiter with an 8-cycle timeout.
module tb_bus_arbiter;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] req0_addr, req0_data, req1_addr, req1_data;
  logic        req0_rw, req0_valid, req1_rw, req1_valid;
  logic        req0_ready_o, req0_rvalid_o, req0_err_o;
  logic        req1_ready_o, req1_rvalid_o, req1_err_o;
  logic [15:0] req0_rdata_o, req1_rdata_o;
  logic [15:0] bus_addr_o, bus_data_o, bus_data_i;
  logic        bus_rw_o, bus_valid_o, bus_rw_i, bus_valid_i;

  int          n_pass = 0;
  int          n_tot  = 0;
  logic [15:0] exp_rd [2];

  // Field order: v0 v1 | a0 d0 rw0 | a1 d1 rw1 | keep lat resp | g err rdata
  typedef struct {
    logic        v0, v1;
    logic [15:0] a0, d0;
    logic        rw0;
    logic [15:0] a1, d1;
    logic        rw1;
    logic        keep;
    int          lat;
    logic [15:0] resp;
    logic        g;
    logic        err;
    logic [15:0] rdata;
  } vec_t;

  vec_t vecs [10];
  vec_t tie_vec;

  bus_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req0_addr_i   (req0_addr),
    .req0_data_i   (req0_data),
    .req0_rw_i     (req0_rw),
    .req0_valid_i  (req0_valid),
    .req0_ready_o  (req0_ready_o),
    .req0_rdata_o  (req0_rdata_o),
    .req0_rvalid_o (req0_rvalid_o),
    .req0_err_o    (req0_err_o),
    .req1_addr_i   (req1_addr),
    .req1_data_i   (req1_data),
    .req1_rw_i     (req1_rw),
    .req1_valid_i  (req1_valid),
    .req1_ready_o  (req1_ready_o),
    .req1_rdata_o  (req1_rdata_o),
    .req1_rvalid_o (req1_rvalid_o),
    .req1_err_o    (req1_err_o),
    .bus_addr_o    (bus_addr_o),
    .bus_data_o    (bus_data_o),
    .bus_rw_o      (bus_rw_o),
    .bus_valid_o   (bus_valid_o),
    .bus_data_i    (bus_data_i),
    .bus_rw_i      (bus_rw_i),
    .bus_valid_i   (bus_valid_i)
  );

  // 10-unit clock period
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " strobes"}, 32'({req1_ready_o, req0_ready_o, req1_rvalid_o, req0_rvalid_o,
                                req1_err_o, req0_err_o, bus_valid_o, bus_rw_o}), 32'd0);
    chk({tag, " bus addr/data"}, {bus_addr_o, bus_data_o}, 32'd0);
    chk({tag, " rdata"}, {req1_rdata_o, req0_rdata_o}, 32'd0);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " strobes"}, 32'({req1_rvalid_o, req0_rvalid_o, bus_valid_o}), 32'd0);
    chk({tag, " rdata held"}, {req1_rdata_o, req0_rdata_o}, {exp_rd[1], exp_rd[0]});
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int          last_c;
    logic [15:0] e_addr, e_data;
    logic        e_rw;
    e_addr = v.g ? v.a1 : v.a0;
    e_data = v.g ? v.d1 : v.d0;
    e_rw   = v.g ? v.rw1 : v.rw0;
    req0_valid = v.v0; req0_addr = v.a0; req0_data = v.d0; req0_rw = v.rw0;
    req1_valid = v.v1; req1_addr = v.a1; req1_data = v.d1; req1_rw = v.rw1;
    #1;
    chk({tag, " ready"}, 32'({req1_ready_o, req0_ready_o}), v.g ? 32'd2 : 32'd1);
    tick();
    if (!v.keep) begin
      if (v.g) req1_valid = 1'b0;
      else     req0_valid = 1'b0;
    end
    chk({tag, " issue valid/rw"}, 32'({bus_valid_o, bus_rw_o}), 32'({1'b1, e_rw}));
    chk({tag, " issue addr/data"}, {bus_addr_o, bus_data_o}, {e_addr, e_data});
    chk({tag, " issue ready"}, 32'({req1_ready_o, req0_ready_o}), 32'd0);
    last_c = (v.lat > 0) ? v.lat + 1 : TMO;
    for (int c = 1; c <= last_c; c++) begin
      tick();
      bus_valid_i = (c == v.lat);
      bus_data_i  = (c == v.lat) ? v.resp : 16'h0000;
      bus_rw_i    = (c == v.lat) ? e_rw : 1'b0;
      if (c < last_c) begin
        chk({tag, " wait quiet"}, 32'({req1_rvalid_o, req0_rvalid_o, req1_ready_o,
                                       req0_ready_o, bus_valid_o, bus_rw_o}), 32'd0);
        chk({tag, " wait bus zero"}, {bus_addr_o, bus_data_o}, 32'd0);
      end else begin
        exp_rd[v.g] = v.rdata;
        chk({tag, " rvalid"}, 32'({req1_rvalid_o, req0_rvalid_o}), v.g ? 32'd2 : 32'd1);
        chk({tag, " err"}, 32'({req1_err_o, req0_err_o}),
            v.err ? (v.g ? 32'd2 : 32'd1) : 32'd0);
        chk({tag, " rdata"}, {req1_rdata_o, req0_rdata_o}, {exp_rd[1], exp_rd[0]});
      end
    end
  endtask

  initial begin
    rst_n = 1'b1;
    req0_valid = 1'b0; req0_addr = 16'h0000; req0_data = 16'h0000; req0_rw = 1'b0;
    req1_valid = 1'b0; req1_addr = 16'h0000; req1_data = 16'h0000; req1_rw = 1'b0;
    bus_valid_i = 1'b0; bus_data_i = 16'h0000; bus_rw_i = 1'b0;
    exp_rd[0] = 16'h0000; exp_rd[1] = 16'h0000;

    vecs[0] = '{1'b1, 1'b1, 16'h0000, 16'h0001, 1'b1, 16'h0002, 16'h0000, 1'b0, 1'b0, 2, 16'h5A5A, 1'b0, 1'b0, 16'h5A5A};
    vecs[1] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0002, 16'h0000, 1'b0, 1'b0, 1, 16'h1111, 1'b1, 1'b0, 16'h1111};
    vecs[2] = '{1'b1, 1'b1, 16'h0010, 16'hA000, 1'b1, 16'h0020, 16'h0000, 1'b0, 1'b1, 4, 16'h2222, 1'b0, 1'b0, 16'h2222};
    vecs[3] = '{1'b1, 1'b1, 16'h0010, 16'hA000, 1'b1, 16'h0020, 16'h0000, 1'b0, 1'b1, 2, 16'h3333, 1'b1, 1'b0, 16'h3333};
    vecs[4] = '{1'b1, 1'b1, 16'h0010, 16'hA000, 1'b1, 16'h0020, 16'h0000, 1'b0, 1'b1, 5, 16'h4444, 1'b0, 1'b0, 16'h4444};
    vecs[5] = '{1'b1, 1'b1, 16'h0010, 16'hA000, 1'b1, 16'h0020, 16'h0000, 1'b0, 1'b1, 1, 16'h5555, 1'b1, 1'b0, 16'h5555};
    vecs[6] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0030, 16'h0000, 1'b0, 1'b0, 7, 16'hC0DE, 1'b1, 1'b0, 16'hC0DE};
    vecs[7] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 16'h00FF, 16'hFFFF, 1'b1, 1'b0, 1, 16'h7777, 1'b1, 1'b0, 16'h7777};
    vecs[8] = '{1'b1, 1'b0, 16'h0001, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 3, 16'hBEEF, 1'b0, 1'b0, 16'hBEEF};
    vecs[9] = '{1'b1, 1'b0, 16'h0300, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 0, 16'h0000, 1'b0, 1'b1, 16'h0000};
    tie_vec = '{1'b1, 1'b1, 16'h0040, 16'h4040, 1'b1, 16'h0050, 16'h0000, 1'b0, 1'b0, 2, 16'hABCD, 1'b0, 1'b0, 16'hABCD};

    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    #2 rst_n = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      run_txn(vecs[i], $sformatf("vec%0d", i));
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Late response two cycles after the timeout strobe must be dropped
    tick();
    tick();
    bus_valid_i = 1'b1; bus_data_i = 16'h9999;
    tick();
    bus_valid_i = 1'b0; bus_data_i = 16'h0000;
    for (int k = 0; k < 3; k++) begin
      chk_quiet($sformatf("late resp c%0d", k));
      tick();
    end

    // Reset in the middle of WAIT abandons the transaction
    req0_valid = 1'b1; req0_addr = 16'h00A0; req0_data = 16'h1234; req0_rw = 1'b1;
    #1;
    chk("midreset ready", 32'({req1_ready_o, req0_ready_o}), 32'd1);
    tick();
    req0_valid = 1'b0;
    tick();
    tick();
    #3 rst_n = 1'b0;
    #1;
    exp_rd[0] = 16'h0000;
    exp_rd[1] = 16'h0000;
    chk_zero("midreset");
    #2 rst_n = 1'b1;
    tick();
    bus_valid_i = 1'b1; bus_data_i = 16'hDEAD;
    tick();
    bus_valid_i = 1'b0; bus_data_i = 16'h0000;
    for (int k = 0; k < 2; k++) begin
      chk_quiet($sformatf("post-reset stray c%0d", k));
      tick();
    end
    run_txn(tie_vec, "post-reset tie");
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
